// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR controller command port among NREQ requesters.
// One command in flight; an owner may chain up to LOCK_MAX commands before the grant rotates.
module ddr_cmd_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 24,
    parameter int LW       = 4,
    parameter int LOCK_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    done,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_rw,
    output logic [AW-1:0]      cmd_addr,
    output logic [LW-1:0]      cmd_len,
    input  logic               xfer_done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_BUSY} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     owner_reg, owner_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic              valid_reg, valid_next;
    logic              rw_reg, rw_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [LW-1:0]     len_reg, len_next;

    logic [AW-1:0]     addr_arr [NREQ];
    logic [LW-1:0]     len_arr  [NREQ];
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign len_arr[gi]  = req_len[gi*LW +: LW];
        end
    endgenerate

    // Scan downward so the last hit written is the first set bit at or after ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_idx = PW'((int'(ptr_reg) + i) % NREQ);
            if (req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        gnt_next   = gnt_reg;
        ack_next   = '0;
        done_next  = '0;
        valid_next = valid_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        case (state_reg)
            // INIT arbitrates in the same cycle init_done is seen, so a pending
            // request is granted one cycle after initialisation completes.
            S_INIT, S_IDLE: begin
                if (state_reg == S_IDLE || init_done) begin
                    state_next = S_IDLE;
                    if (pick_found) begin
                        owner_next = pick_idx;
                        gnt_next   = NREQ'(1) << pick_idx;
                        valid_next = 1'b1;
                        rw_next    = req_rw[pick_idx];
                        addr_next  = addr_arr[pick_idx];
                        len_next   = len_arr[pick_idx];
                        cnt_next   = CW'(1);
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    ack_next   = gnt_reg;
                    valid_next = 1'b0;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (xfer_done) begin
                    done_next = gnt_reg;
                    if (req[owner_reg] && cnt_reg < CW'(LOCK_MAX)) begin
                        valid_next = 1'b1;
                        rw_next    = req_rw[owner_reg];
                        addr_next  = addr_arr[owner_reg];
                        len_next   = len_arr[owner_reg];
                        cnt_next   = cnt_reg + CW'(1);
                        state_next = S_ISSUE;
                    end else begin
                        gnt_next   = '0;
                        ptr_next   = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + PW'(1);
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_INIT;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            done_reg  <= '0;
            valid_reg <= 1'b0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            done_reg  <= done_next;
            valid_reg <= valid_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
        end
    end

    assign gnt       = gnt_reg;
    assign ack       = ack_reg;
    assign done      = done_reg;
    assign cmd_valid = valid_reg;
    assign cmd_rw    = rw_reg;
    assign cmd_addr  = addr_reg;
    assign cmd_len   = len_reg;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Scoreboard bench for ddr_cmd_arbiter: expected owners are queued when requests are
// driven and popped as the arbiter presents each command to the controller model.
module tb_ddr_cmd_arbiter;
    localparam int NREQ     = 4;
    localparam int AW       = 24;
    localparam int LW       = 4;
    localparam int LOCK_MAX = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_done;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ-1:0]    gnt, ack, done;
    logic               cmd_valid, cmd_ready, cmd_rw, xfer_done;
    logic [AW-1:0]      cmd_addr;
    logic [LW-1:0]      cmd_len;

    logic [AW-1:0]      t_addr [NREQ];
    logic [LW-1:0]      t_len  [NREQ];
    logic [NREQ-1:0]    t_rw;

    int total = 0;
    int bad   = 0;
    int tb_ptr = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(.NREQ(NREQ), .AW(AW), .LW(LW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .ack(ack), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .xfer_done(xfer_done)
    );

    always_comb begin
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = t_addr[i];
            req_len[i*LW +: LW]  = t_len[i];
        end
        req_rw = t_rw;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_from(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    // Expected owner order for a held request mask: each owner gets LOCK_MAX commands, then rotate.
    task automatic gen(input logic [NREQ-1:0] m, input int n);
        int o, c, p, last_o;
        p = tb_ptr;
        o = first_from(m, p);
        c = 1;
        last_o = o;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(o);
            last_o = o;
            if (c < LOCK_MAX) c++;
            else begin
                p = (o + 1) % NREQ;
                o = first_from(m, p);
                c = 1;
            end
        end
        tb_ptr = (last_o + 1) % NREQ;
    endtask

    task automatic serve(input int stall, input bit last);
        int o, n;
        logic [NREQ-1:0] oh;
        bit lock;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_val("cmd_valid_seen", cmd_valid, 1);
        check_val("sb_nonempty", (exp_q.size() > 0), 1);
        if (cmd_valid !== 1'b1 || exp_q.size() == 0) return;
        o  = exp_q.pop_front();
        oh = NREQ'(1) << o;
        check_val("gnt", gnt, oh);
        check_val("cmd_addr", cmd_addr, t_addr[o]);
        check_val("cmd_rw", cmd_rw, t_rw[o]);
        check_val("cmd_len", cmd_len, t_len[o]);
        for (int s = 0; s < stall; s++) begin
            xfer_done = (s == 1);
            tick();
            xfer_done = 1'b0;
            check_val("stall_valid", cmd_valid, 1);
            check_val("stall_addr", cmd_addr, t_addr[o]);
            check_val("stall_ack", ack, 0);
            check_val("stall_done", done, 0);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_val("ack", ack, oh);
        check_val("valid_drop", cmd_valid, 0);
        check_val("gnt_busy", gnt, oh);
        repeat (2) tick();
        check_val("ack_pulse", ack, 0);
        if (last) req = '0;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        check_val("done", done, oh);
        lock = !last && exp_q.size() > 0 && exp_q[0] == o;
        check_val("reissue_t1", cmd_valid, lock);
        if (lock) check_val("relatch_addr", cmd_addr, t_addr[o]);
        else      check_val("gnt_release", gnt, 0);
        tick();
        check_val("done_pulse", done, 0);
        if (!last && !lock) check_val("rotate_t2", cmd_valid, 1);
        $display("txn owner=%0d addr=%h rw=%0d len=%0d stall=%0d lock_next=%0d", o, t_addr[o], t_rw[o], t_len[o], stall, lock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        t_addr[0] = 24'h0A0010; t_addr[1] = 24'h000123; t_addr[2] = 24'h5F00C0; t_addr[3] = 24'hFFFFF0;
        t_len[0]  = 4'd2;       t_len[1]  = 4'd4;       t_len[2]  = 4'd8;       t_len[3]  = 4'd15;
        t_rw      = 4'b0110;
        rst = 1'b1; init_done = 1'b0; req = '0; cmd_ready = 1'b0; xfer_done = 1'b0;
        repeat (3) tick();
        check_val("rst_gnt", gnt, 0);
        check_val("rst_valid", cmd_valid, 0);
        check_val("rst_addr", cmd_addr, 0);
        check_val("rst_ack_done", {ack, done}, 0);
        rst = 1'b0;

        // Requests wait until initialisation completes.
        for (int c = 0; c < 50; c++) begin
            if (c == 5) req = 4'b0001;
            tick();
            if (c % 10 == 9) check_val("pre_init_gnt", gnt, 0);
        end
        gen(4'b0001, 1);
        init_done = 1'b1;
        tick();
        check_val("init_gnt", gnt, 4'b0001);
        check_val("init_valid", cmd_valid, 1);
        init_done = 1'b0;
        serve(0, 1);

        // Single read from requester 1 with a stalled controller.
        req = 4'b0010;
        gen(4'b0010, 1);
        serve(5, 1);

        // All requesters held: two commands per owner, rotating.
        req = 4'b1111;
        gen(4'b1111, 9);
        for (int k = 0; k < 9; k++) serve((k == 3) ? 2 : 0, k == 8);

        // Two requesters held.
        req = 4'b0101;
        gen(4'b0101, 5);
        for (int k = 0; k < 5; k++) serve(0, k == 4);

        // Reset while BUSY.
        req = 4'b1000;
        for (int n = 0; n < 50 && cmd_valid !== 1'b1; n++) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_val("pre_rst_ack", ack, 4'b1000);
        tick();
        rst = 1'b1;
        #1;
        check_val("async_rst_gnt", gnt, 0);
        check_val("async_rst_valid", cmd_valid, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check_val("post_rst_no_gnt", gnt, 0);
        tb_ptr = 0;
        gen(4'b1000, 1);
        init_done = 1'b1;
        tick();
        check_val("reinit_gnt", gnt, 4'b1000);
        serve(0, 1);
        check_val("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
